stream_adder: RTL and testbench

//  Multi-lane streaming adder, the parametrised successor of the single-bit combinational adder test design.

---
 rtl/stream_adder_pkg.sv | 24 ++
 rtl/stream_adder_if.sv | 35 +++
 rtl/stream_adder_fifo.sv | 65 ++++++
 rtl/stream_adder.sv | 83 ++++++++
 tb/tb_stream_adder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_adder_pkg.sv
// stream_adder_pkg: shared types for the multi-lane streaming adder.
//   mode_e     : beat operation, ADD (a+b) or ACC (acc+a)
//   lane_res_t : one lane's result {carry, sum} at the default lane width
//   ptr_w()    : pointer width for a FIFO of a given depth
// Optional feature macro used by the design: ADDER_SAT_EN (saturating lanes).
package stream_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  localparam int unsigned LANE_W_DEF = 8;

  typedef struct packed {
    logic                  carry;
    logic [LANE_W_DEF-1:0] sum;
  } lane_res_t;

  function automatic int unsigned ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_adder_if.sv
// stream_adder_if: beat-in / result-out handshake bundle of stream_adder.
//   IN_valid/OUT_ready          : input beat handshake
//   IN_a, IN_b, IN_mode, IN_clr : beat payload and accumulator clear
//   OUT_valid/IN_ready          : result handshake
//   OUT_sum, OUT_carry          : head result
// Modports: master (producer/consumer side), slave (the adder).
interface stream_adder_if
  import stream_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
);

  logic                   IN_valid;
  logic                   OUT_ready;
  logic [LANES*WIDTH-1:0] IN_a;
  logic [LANES*WIDTH-1:0] IN_b;
  mode_e                  IN_mode;
  logic                   IN_clr;
  logic                   OUT_valid;
  logic                   IN_ready;
  logic [LANES*WIDTH-1:0] OUT_sum;
  logic [LANES-1:0]       OUT_carry;

  modport master (
    output IN_valid, IN_a, IN_b, IN_mode, IN_clr, IN_ready,
    input  OUT_ready, OUT_valid, OUT_sum, OUT_carry
  );

  modport slave (
    input  IN_valid, IN_a, IN_b, IN_mode, IN_clr, IN_ready,
    output OUT_ready, OUT_valid, OUT_sum, OUT_carry
  );

endinterface

// File: rtl/stream_adder_fifo.sv
// stream_adder_fifo: generic DEPTH x DW synchronous FIFO, synchronous active-low reset.
//   clk_i, rst_n_i : clock, reset (clears pointers, count and every entry)
//   push_i, data_i : write; caller guarantees no push while full
//   pop_i          : read; caller guarantees no pop while empty
//   data_o         : head entry (registered storage, no bypass)
//   full_o, empty_o: derived from the registered count only
module stream_adder_fifo
  import stream_adder_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 18
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PTR_ONE;
    if (pop_i)  rd_d = rd_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/stream_adder.sv
// stream_adder: LANES independent WIDTH-bit adders fed by a valid/ready beat
// stream, results buffered in a DEPTH-entry output FIFO.
//   IN_clk   : sole clock, rising edge
//   IN_rst_n : synchronous reset, active-low
//   bus      : stream_adder_if.slave (beat in, result out)
// Mode ADD: sum = a + b. Mode ACC: sum = acc + a, acc updated on push.
// Optional: define ADDER_SAT_EN to clamp a carrying lane to all-ones
// (carry still reported, accumulator holds the clamped value).
module stream_adder
  import stream_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic           IN_clk,
  input  logic           IN_rst_n,
  stream_adder_if.slave  bus
);

  localparam int unsigned DW = LANES * (WIDTH + 1);

  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic                   is_acc;
  logic [LANES*WIDTH-1:0] res_sum;
  logic [LANES-1:0]       res_carry;
  logic [DW-1:0]          head;

  // Ready depends on registered occupancy only; a pop frees its slot next cycle.
  assign bus.OUT_ready = ~fifo_full;
  assign bus.OUT_valid = ~fifo_empty;
  assign push          = bus.IN_valid & ~fifo_full;
  assign pop           = ~fifo_empty & bus.IN_ready;
  assign is_acc        = (bus.IN_mode == MODE_ACC);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_op, b_op, res;
    logic [WIDTH:0]   full_sum;

    assign a_op = bus.IN_a[i*WIDTH +: WIDTH];
    // A clear coinciding with an ACC push makes this beat start from zero.
    assign b_op = is_acc ? (bus.IN_clr ? '0 : acc_q) : bus.IN_b[i*WIDTH +: WIDTH];
    assign full_sum = {1'b0, a_op} + {1'b0, b_op};

`ifdef ADDER_SAT_EN
    assign res = full_sum[WIDTH] ? '1 : full_sum[WIDTH-1:0];
`else
    assign res = full_sum[WIDTH-1:0];
`endif

    always_ff @(posedge IN_clk) begin
      if (!IN_rst_n) begin
        acc_q <= '0;
      end else if (push && is_acc) begin
        acc_q <= res;
      end else if (bus.IN_clr) begin
        acc_q <= '0;
      end
    end

    assign res_sum[i*WIDTH +: WIDTH] = res;
    assign res_carry[i]              = full_sum[WIDTH];
  end

  stream_adder_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk_i   (IN_clk),
    .rst_n_i (IN_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({res_carry, res_sum}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {bus.OUT_carry, bus.OUT_sum} = head;

endmodule

// File: tb/tb_stream_adder.sv
module tb_stream_adder;
  import stream_adder_pkg::*;

  localparam int W = 8;
  localparam int L = 2;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_adder_if #(.WIDTH(W), .LANES(L)) bus ();

  stream_adder #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .IN_clk   (clk),
    .IN_rst_n (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic [1:0]  carry;
  } ent_t;

  ent_t mq[$];
  int   acc[L];

  typedef struct {
    bit          v;
    mode_e       m;
    bit          clr;
    logic [15:0] a;
    logic [15:0] b;
    bit          ev;
    logic [15:0] es;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic lane_res_t lane_calc(input int a, input int o);
    lane_res_t r;
    int s;
    s = a + o;
    r.carry = (s > 255);
    r.sum   = 8'(s % 256);
`ifdef ADDER_SAT_EN
    if (r.carry) r.sum = 8'hFF;
`endif
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.OUT_valid}, {31'd0, mq.size() != 0});
    chk({tag, ".ready"}, {31'd0, bus.OUT_ready}, {31'd0, mq.size() != D});
    if (mq.size() > 0) begin
      chk({tag, ".sum"},   {16'd0, bus.OUT_sum},   {16'd0, mq[0].sum});
      chk({tag, ".carry"}, {30'd0, bus.OUT_carry}, {30'd0, mq[0].carry});
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare at negedge.
  task automatic step(input bit v, input mode_e m, input bit clr, input bit rdy,
                      input logic [15:0] a, input logic [15:0] b, input string tag);
    bit push, pop;
    ent_t e;
    lane_res_t r;
    int opnd;
    bus.IN_valid = v;
    bus.IN_mode  = m;
    bus.IN_clr   = clr;
    bus.IN_ready = rdy;
    bus.IN_a     = a;
    bus.IN_b     = b;
    @(posedge clk);
    push = v && (mq.size() < D);
    pop  = (mq.size() > 0) && rdy;
    e = '0;
    if (push) begin
      for (int i = 0; i < L; i++) begin
        if (m == MODE_ACC) opnd = clr ? 0 : acc[i];
        else               opnd = int'(b[i*8 +: 8]);
        r = lane_calc(int'(a[i*8 +: 8]), opnd);
        e.sum[i*8 +: 8] = r.sum;
        e.carry[i]      = r.carry;
        if (m == MODE_ACC) acc[i] = int'(r.sum);
        else if (clr)      acc[i] = 0;
      end
    end else if (clr) begin
      for (int i = 0; i < L; i++) acc[i] = 0;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.IN_valid = 1'b0;
    bus.IN_clr   = 1'b0;
    bus.IN_ready = 1'b0;
    bus.IN_mode  = MODE_ADD;
    bus.IN_a     = '0;
    bus.IN_b     = '0;
    @(posedge clk);
    mq.delete();
    for (int i = 0; i < L; i++) acc[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst.valid", {31'd0, bus.OUT_valid}, 32'd0);
    chk("rst.ready", {31'd0, bus.OUT_ready}, 32'd1);
    chk("rst.sum",   {16'd0, bus.OUT_sum},   32'd0);
    chk("rst.carry", {30'd0, bus.OUT_carry}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    mode_e rm;

`ifdef ADDER_SAT_EN
    tbl[0]  = '{1, MODE_ADD, 0, 16'hFF10, 16'h0205, 1, 16'hFF15, 2'b10};
    tbl[6]  = '{1, MODE_ADD, 0, 16'h0080, 16'h0080, 1, 16'h00FF, 2'b01};
    tbl[7]  = '{1, MODE_ACC, 0, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 2'b11};
    tbl[8]  = '{1, MODE_ACC, 0, 16'h0202, 16'h0000, 1, 16'hFFFF, 2'b11};
`else
    tbl[0]  = '{1, MODE_ADD, 0, 16'hFF10, 16'h0205, 1, 16'h0115, 2'b10};
    tbl[6]  = '{1, MODE_ADD, 0, 16'h0080, 16'h0080, 1, 16'h0000, 2'b01};
    tbl[7]  = '{1, MODE_ACC, 0, 16'hFFFF, 16'h0000, 1, 16'h0000, 2'b11};
    tbl[8]  = '{1, MODE_ACC, 0, 16'h0202, 16'h0000, 1, 16'h0202, 2'b00};
`endif
    tbl[1]  = '{1, MODE_ACC, 1, 16'h0303, 16'h0000, 1, 16'h0303, 2'b00};
    tbl[2]  = '{1, MODE_ACC, 0, 16'h0404, 16'h0000, 1, 16'h0707, 2'b00};
    tbl[3]  = '{1, MODE_ACC, 0, 16'h0505, 16'h0000, 1, 16'h0C0C, 2'b00};
    tbl[4]  = '{0, MODE_ACC, 1, 16'h0000, 16'h0000, 0, 16'h0000, 2'b00};
    tbl[5]  = '{1, MODE_ACC, 0, 16'h0101, 16'h0000, 1, 16'h0101, 2'b00};
    tbl[9]  = '{1, MODE_ADD, 1, 16'h0101, 16'h0101, 1, 16'h0202, 2'b00};
    tbl[10] = '{1, MODE_ACC, 0, 16'h0606, 16'h0000, 1, 16'h0606, 2'b00};

    do_reset();

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].v, tbl[k].m, tbl[k].clr, 1'b1, tbl[k].a, tbl[k].b, "tbl");
      chk("tbl.vec_valid", {31'd0, bus.OUT_valid}, {31'd0, tbl[k].ev});
      if (tbl[k].ev) begin
        chk("tbl.vec_sum",   {16'd0, bus.OUT_sum},   {16'd0, tbl[k].es});
        chk("tbl.vec_carry", {30'd0, bus.OUT_carry}, {30'd0, tbl[k].ec});
      end
    end

    // Backpressure: two beats fill the FIFO, the third stalls until space frees.
    step(0, MODE_ADD, 0, 1, 16'h0, 16'h0, "bp.idle");
    step(1, MODE_ADD, 0, 0, 16'h0101, 16'h0101, "bp.p1");
    step(1, MODE_ADD, 0, 0, 16'h0202, 16'h0101, "bp.p2");
    chk("bp.full_ready", {31'd0, bus.OUT_ready}, 32'd0);
    step(1, MODE_ADD, 0, 0, 16'h0303, 16'h0101, "bp.p3");
    chk("bp.head1", {16'd0, bus.OUT_sum}, 32'h0202);
    step(1, MODE_ADD, 0, 1, 16'h0303, 16'h0101, "bp.r1");
    chk("bp.head2", {16'd0, bus.OUT_sum}, 32'h0303);
    step(1, MODE_ADD, 0, 1, 16'h0303, 16'h0101, "bp.r2");
    chk("bp.head3", {16'd0, bus.OUT_sum}, 32'h0404);
    step(0, MODE_ADD, 0, 1, 16'h0, 16'h0, "bp.drain");
    chk("bp.empty", {31'd0, bus.OUT_valid}, 32'd0);

    // Continuous streaming: exactly one entry in flight every cycle.
    for (int k = 0; k < 16; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = mode_e'($urandom_range(0, 1));
      step(1, rm, ($urandom_range(0, 7) == 0), 1, ra, rb, "stream");
      chk("stream.one", {31'd0, bus.OUT_valid}, 32'd1);
    end

    // Fully random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = mode_e'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), rm, ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), ra, rb, "rand");
    end

    // Reset with buffered entries and nonzero accumulators.
    step(1, MODE_ACC, 0, 0, 16'h0707, 16'h0, "mr.p1");
    step(1, MODE_ACC, 0, 0, 16'h0303, 16'h0, "mr.p2");
    do_reset();
    step(1, MODE_ACC, 0, 1, 16'h0909, 16'h0, "mr.acc");
    chk("mr.acc9", {16'd0, bus.OUT_sum}, 32'h0909);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
